// File: rtl/imc_mac_sequencer.sv
// imc_mac_sequencer: Wishbone-controlled sequencer for an in-memory-compute MAC array.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i/adr_i/dat_i   Wishbone classic slave request
//   wbs_dat_o, wbs_ack_o          Wishbone read data / one-cycle acknowledge
//   empty_*/full_*                buffer status flags (IB, WB, SA, OB)
//   en_vclp                       clamp-voltage precharge enable
//   mac_start                     array evaluate strobe
//   ob_demux                      output-buffer column select (CFG[1:0])
//   opcode_o, int_state, ext_state  observability
//   irq                           one-cycle pulse on entry to DONE or ERR
//
// Register window (word offsets from BASE_ADDR):
//   0x0 CMD    W   [2:0] opcode, [8] go
//   0x4 CFG    R/W [1:0] ob_demux
//   0x8 STATUS R   [0] busy [1] done [2] error [3] overrun [6:4] int_state
//                  [9:8] ext_state [14:12] latched opcode
module imc_mac_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned PRECH_CYC = 4,
    parameter int unsigned EVAL_CYC  = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic        empty_IB,
    input  logic        full_IB,
    input  logic        empty_WB,
    input  logic        full_WB,
    input  logic        empty_SA,
    input  logic        full_SA,
    input  logic        empty_OB,
    input  logic        full_OB,
    output logic        en_vclp,
    output logic        mac_start,
    output logic [1:0]  ob_demux,
    output logic [2:0]  opcode_o,
    output logic [2:0]  int_state,
    output logic [1:0]  ext_state,
    output logic        irq
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCheck = 3'd1,
        StPrech = 3'd2,
        StEval  = 3'd3,
        StCapt  = 3'd4,
        StDone  = 3'd5,
        StErr   = 3'd6
    } state_t;

    localparam logic [1:0] OffCmd    = 2'd0;
    localparam logic [1:0] OffCfg    = 2'd1;
    localparam logic [1:0] OffStatus = 2'd2;

    localparam logic [7:0] PrechLoad = 8'(PRECH_CYC - 1);
    localparam logic [7:0] EvalLoad  = 8'(EVAL_CYC - 1);
    localparam logic [7:0] CaptLoad  = 8'(TIMEOUT - 1);

    state_t      r_state, w_state_d;
    logic [7:0]  r_cnt, w_cnt_d;
    logic        r_irq, w_irq_d;
    logic [2:0]  r_opcode;
    logic        r_done, r_error, r_overrun;
    logic [1:0]  r_cfg;
    logic        r_ack, r_served;
    logic [31:0] r_rdata;

    logic        w_sel, w_accept, w_go, w_busy, w_start;
    logic        w_enter_done, w_enter_err;
    logic [1:0]  w_off, w_ext;
    logic [31:0] w_status;
    logic        w_unused;

    // Inputs with no function in this block.
    assign w_unused = ^{full_IB, full_WB, empty_OB, full_OB, wbs_adr_i[1:0],
                        wbs_dat_i[31:9], wbs_dat_i[7:3]};

    // ---------------- Wishbone slave ----------------
    assign w_sel    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // r_served blocks a second ack until stb drops, so a held strobe acks once.
    assign w_accept = w_sel & ~r_served;
    assign w_off    = wbs_adr_i[3:2];
    assign w_go     = w_accept & wbs_we_i & (w_off == OffCmd) & wbs_dat_i[8];
    assign w_busy   = (r_state == StCheck) | (r_state == StPrech) |
                      (r_state == StEval)  | (r_state == StCapt);
    assign w_start  = w_go & ~w_busy;

    always_comb begin
        w_ext = 2'd0;
        unique case (r_state)
            StIdle:  w_ext = 2'd0;
            StDone:  w_ext = 2'd2;
            StErr:   w_ext = 2'd3;
            default: w_ext = 2'd1;
        endcase
    end

    assign w_status = {17'b0, r_opcode, 2'b0, w_ext, 1'b0, r_state,
                       r_overrun, r_error, r_done, w_busy};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_served <= 1'b0;
            r_rdata  <= 32'd0;
            r_cfg    <= 2'd0;
        end else begin
            r_ack   <= w_accept;
            r_rdata <= 32'd0;
            if (!(wbs_cyc_i && wbs_stb_i)) begin
                r_served <= 1'b0;
            end else if (w_accept) begin
                r_served <= 1'b1;
            end
            if (w_accept && !wbs_we_i) begin
                if (w_off == OffCfg) begin
                    r_rdata <= {30'd0, r_cfg};
                end else if (w_off == OffStatus) begin
                    r_rdata <= w_status;
                end
            end
            if (w_accept && wbs_we_i && (w_off == OffCfg)) begin
                r_cfg <= wbs_dat_i[1:0];
            end
        end
    end

    // ---------------- Sequencer FSM ----------------
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle, StDone, StErr: begin
                if (w_go) begin
                    w_state_d = StCheck;
                end
            end
            StCheck: begin
                unique case (r_opcode)
                    3'd0: w_state_d = StDone;
                    3'd1: begin
                        if (!empty_IB && !empty_WB && !full_SA) begin
                            w_state_d = StPrech;
                            w_cnt_d   = PrechLoad;
                        end else begin
                            w_state_d = StErr;
                        end
                    end
                    3'd2: begin
                        w_state_d = StPrech;
                        w_cnt_d   = PrechLoad;
                    end
                    default: w_state_d = StErr;
                endcase
            end
            StPrech: begin
                if (r_cnt == 8'd0) begin
                    if (r_opcode == 3'd1) begin
                        w_state_d = StEval;
                        w_cnt_d   = EvalLoad;
                    end else begin
                        w_state_d = StDone;
                    end
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StEval: begin
                if (r_cnt == 8'd0) begin
                    w_state_d = StCapt;
                    w_cnt_d   = CaptLoad;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StCapt: begin
                if (!empty_SA) begin
                    w_state_d = StDone;
                end else if (r_cnt == 8'd0) begin
                    w_state_d = StErr;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_enter_done = (w_state_d == StDone) && (r_state != StDone);
    assign w_enter_err  = (w_state_d == StErr)  && (r_state != StErr);
    assign w_irq_d      = w_enter_done | w_enter_err;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= StIdle;
            r_cnt     <= 8'd0;
            r_irq     <= 1'b0;
            r_opcode  <= 3'd0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_irq   <= w_irq_d;
            if (w_start) begin
                r_opcode  <= wbs_dat_i[2:0];
                r_done    <= 1'b0;
                r_error   <= 1'b0;
                r_overrun <= 1'b0;
            end else if (w_go) begin
                r_overrun <= 1'b1;
            end
            if (w_enter_done) begin
                r_done <= 1'b1;
            end
            if (w_enter_err) begin
                r_error <= 1'b1;
            end
        end
    end

    // ---------------- Outputs ----------------
    assign en_vclp   = (r_state == StPrech);
    assign mac_start = (r_state == StEval);
    assign ob_demux  = r_cfg;
    assign opcode_o  = r_opcode;
    assign int_state = r_state;
    assign ext_state = w_ext;
    assign irq       = r_irq;
    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdata;

endmodule

// File: tb/tb_imc_mac_sequencer.sv
// Directed self-checking bench for imc_mac_sequencer.
module tb_imc_mac_sequencer;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CMD  = BASE + 32'h0;
    localparam logic [31:0] A_CFG  = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;

    logic        clk, rst;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat, rdat;
    logic        ack;
    logic        empty_IB, full_IB, empty_WB, full_WB;
    logic        empty_SA, full_SA, empty_OB, full_OB;
    logic        en_vclp, mac_start, irq;
    logic [1:0]  ob_demux, ext_state;
    logic [2:0]  opcode_o, int_state;

    int n_checks = 0;
    int n_fail   = 0;

    imc_mac_sequencer dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_dat_o (rdat),
        .wbs_ack_o (ack),
        .empty_IB  (empty_IB),
        .full_IB   (full_IB),
        .empty_WB  (empty_WB),
        .full_WB   (full_WB),
        .empty_SA  (empty_SA),
        .full_SA   (full_SA),
        .empty_OB  (empty_OB),
        .full_OB   (full_OB),
        .en_vclp   (en_vclp),
        .mac_start (mac_start),
        .ob_demux  (ob_demux),
        .opcode_o  (opcode_o),
        .int_state (int_state),
        .ext_state (ext_state),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus drivers: drive and sample on the falling edge, bounded ack wait.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic ok);
        ok = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) begin
                ok = 1'b1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ok);
        ok = 1'b0;
        d  = 32'hDEAD_BEEF;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) begin
                ok = 1'b1;
                d  = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        ok;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({en_vclp, mac_start, irq, ob_demux, opcode_o, int_state, ext_state, ack, rdat} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vclp=%b mac=%b irq=%b st=%0d ext=%0d want all 0",
                     en_vclp, mac_start, irq, int_state, ext_state);
        end
        rst = 1'b0;
        bus_read(A_STAT, d, ok);
        n_checks++;
        if ({ok, d} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_status: got ack=%b data=%h want ack=1 data=0", ok, d);
        end
        bus_read(A_CFG, d, ok);
        n_checks++;
        if ({ok, d} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_cfg: got ack=%b data=%h want ack=1 data=0", ok, d);
        end
    endtask

    task automatic test_bus();
        logic [31:0] d;
        logic        ok;
        bus_write(A_CFG, 32'h3, ok);
        n_checks++;
        if ({ok, ob_demux} !== {1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL cfg_write: got ack=%b ob_demux=%0d want ack=1 ob_demux=3", ok, ob_demux);
        end
        bus_read(A_CFG, d, ok);
        n_checks++;
        if (d !== 32'h3) begin
            n_fail++;
            $display("FAIL cfg_read: got %h want 00000003", d);
        end
        bus_write(A_CFG, 32'hFFFF_FFF6, ok);
        n_checks++;
        if (ob_demux !== 2'd2) begin
            n_fail++;
            $display("FAIL cfg_mask: got %0d want 2", ob_demux);
        end
        bus_write(32'h4000_0000, 32'h0, ok);
        n_checks++;
        if (ok !== 1'b0) begin
            n_fail++;
            $display("FAIL undecoded_ack: got ack=%b want 0", ok);
        end
        bus_write(A_STAT, 32'hFFFF_FFFF, ok);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_write_ack: got %b want 1", ok);
        end
        bus_read(A_STAT, d, ok);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL status_ro: got %h want 00000000", d);
        end
        bus_read(A_CMD, d, ok);
        n_checks++;
        if ({ok, d} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL cmd_read_zero: got ack=%b data=%h want ack=1 data=0", ok, d);
        end
        // Held strobe: exactly one ack, then low while stb stays up.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CFG;
        @(negedge clk);
        d[0] = ack;
        @(negedge clk);
        d[1] = ack;
        @(negedge clk);
        d[2] = ack;
        cyc = 1'b0; stb = 1'b0;
        n_checks++;
        if (d[2:0] !== 3'b001) begin
            n_fail++;
            $display("FAIL ack_single: got pattern %b want 001", d[2:0]);
        end
        bus_write(A_CFG, 32'h0, ok);
    endtask

    task automatic test_opcodes();
        logic [2:0] ops  [3] = '{3'd0, 3'd2, 3'd5};
        logic [2:0] exps [3] = '{3'd5, 3'd5, 3'd6};
        logic [1:0] exte [3] = '{2'd2, 2'd2, 2'd3};
        logic       ok;
        for (int k = 0; k < 3; k++) begin
            bus_write(A_CMD, {23'd0, 1'b1, 5'd0, ops[k]}, ok);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (int_state == 3'd5 || int_state == 3'd6) break;
            end
            n_checks++;
            if ({int_state, ext_state, opcode_o} !== {exps[k], exte[k], ops[k]}) begin
                n_fail++;
                $display("FAIL opcode_%0d: got st=%0d ext=%0d op=%0d want st=%0d ext=%0d op=%0d",
                         ops[k], int_state, ext_state, opcode_o, exps[k], exte[k], ops[k]);
            end
        end
    endtask

    task automatic test_mac();
        int          cv = 0, cm = 0, ci = 0, capt = 0;
        logic [31:0] d;
        logic        ok;
        bus_write(A_CMD, 32'h101, ok);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cv += int'(en_vclp);
            cm += int'(mac_start);
            ci += int'(irq);
            if (int_state == 3'd4) begin
                capt++;
                if (capt == 3) empty_SA = 1'b0;
            end
        end
        empty_SA = 1'b1;
        n_checks++;
        if (cv != 4 || cm != 8) begin
            n_fail++;
            $display("FAIL mac_pulses: got vclp=%0d mac=%0d want vclp=4 mac=8", cv, cm);
        end
        n_checks++;
        if (ci != 1 || capt != 3 || int_state !== 3'd5) begin
            n_fail++;
            $display("FAIL mac_done: got irq=%0d capt=%0d st=%0d want irq=1 capt=3 st=5",
                     ci, capt, int_state);
        end
        bus_read(A_STAT, d, ok);
        n_checks++;
        if (d !== 32'h0000_1252) begin
            n_fail++;
            $display("FAIL mac_status: got %h want 00001252", d);
        end
    endtask

    task automatic test_mac_error();
        int          cv = 0, cm = 0, ci = 0;
        logic [31:0] d;
        logic        ok;
        empty_WB = 1'b1;
        bus_write(A_CMD, 32'h101, ok);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cv += int'(en_vclp);
            cm += int'(mac_start);
            ci += int'(irq);
        end
        empty_WB = 1'b0;
        n_checks++;
        if (cv != 0 || cm != 0 || ci != 1 || int_state !== 3'd6) begin
            n_fail++;
            $display("FAIL precheck_err: got vclp=%0d mac=%0d irq=%0d st=%0d want 0 0 1 6",
                     cv, cm, ci, int_state);
        end
        bus_read(A_STAT, d, ok);
        n_checks++;
        if (d !== 32'h0000_1364) begin
            n_fail++;
            $display("FAIL precheck_status: got %h want 00001364", d);
        end
    endtask

    task automatic test_timeout();
        int          capt = 0;
        logic        irq_at_err = 1'b0;
        logic [31:0] d;
        logic        ok;
        bus_write(A_CMD, 32'h101, ok);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (int_state == 3'd4) capt++;
            if (int_state == 3'd6) begin
                irq_at_err = irq;
                break;
            end
        end
        n_checks++;
        if (capt != 255 || int_state !== 3'd6 || irq_at_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout: got capt=%0d st=%0d irq=%b want capt=255 st=6 irq=1",
                     capt, int_state, irq_at_err);
        end
        bus_read(A_STAT, d, ok);
        n_checks++;
        if (d !== 32'h0000_1364) begin
            n_fail++;
            $display("FAIL timeout_status: got %h want 00001364", d);
        end
    endtask

    task automatic test_overrun();
        int          cv = 0, cm = 0, ci = 0, ev = 0, capt = 0;
        logic        bus_on = 1'b0, ack_seen = 1'b0;
        logic [31:0] d;
        logic        ok;
        bus_write(A_CMD, 32'h101, ok);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cv += int'(en_vclp);
            cm += int'(mac_start);
            ci += int'(irq);
            if (bus_on && ack) begin
                ack_seen = 1'b1;
                bus_on   = 1'b0;
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
            end
            if (int_state == 3'd3) begin
                ev++;
                if (ev == 2) begin
                    bus_on = 1'b1;
                    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CMD; wdat = 32'h103;
                end
            end
            if (int_state == 3'd4) begin
                capt++;
                if (capt == 1) empty_SA = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        empty_SA = 1'b1;
        n_checks++;
        if (cv != 4 || cm != 8 || ci != 1 || ack_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_timing: got vclp=%0d mac=%0d irq=%0d ack=%b want 4 8 1 1",
                     cv, cm, ci, ack_seen);
        end
        bus_read(A_STAT, d, ok);
        n_checks++;
        if (d !== 32'h0000_125A) begin
            n_fail++;
            $display("FAIL overrun_status: got %h want 0000125a", d);
        end
    endtask

    task automatic test_reset_mid();
        int          cv = 0, cm = 0, ci = 0;
        logic        found = 1'b0;
        logic [31:0] d;
        logic        ok;
        bus_write(A_CFG, 32'h2, ok);
        bus_write(A_CMD, 32'h101, ok);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (int_state == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_eval: got found=%b want 1", found);
        end
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CFG;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({en_vclp, mac_start, irq, ob_demux, opcode_o, int_state, ext_state, ack, rdat} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got vclp=%b mac=%b st=%0d op=%0d demux=%0d want all 0",
                     en_vclp, mac_start, int_state, opcode_o, ob_demux);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_ack: got %b want 0", ack);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        rst = 1'b0;
        bus_read(A_STAT, d, ok);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_status: got %h want 00000000", d);
        end
        bus_write(A_CMD, 32'h102, ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cv += int'(en_vclp);
            cm += int'(mac_start);
            ci += int'(irq);
        end
        n_checks++;
        if (cv != 4 || cm != 0 || ci != 1 || int_state !== 3'd5 || opcode_o !== 3'd2) begin
            n_fail++;
            $display("FAIL prech_only: got vclp=%0d mac=%0d irq=%0d st=%0d op=%0d want 4 0 1 5 2",
                     cv, cm, ci, int_state, opcode_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; wdat = 32'h0;
        empty_IB = 1'b0; full_IB = 1'b0; empty_WB = 1'b0; full_WB = 1'b0;
        empty_SA = 1'b1; full_SA = 1'b0; empty_OB = 1'b0; full_OB = 1'b0;
        test_reset();
        test_bus();
        test_opcodes();
        test_mac();
        test_mac_error();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
